// File: rtl/lock_pkg.sv
// Shared types and width helpers for the keypad lock controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lock_pkg;

   localparam int DEF_NDIG = 4;
   localparam int DEF_DW   = 4;
   localparam int CODE_W   = DEF_NDIG * DEF_DW;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_CHECK,
      ST_FAIL,
      ST_OPEN,
      ST_PROG,
      ST_COMMIT,
      ST_LOCKOUT
   } lock_state_t;

   // Bits needed to count 0..n inclusive.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   // Bits needed for a down-counter loaded with (max(a,b) - 1).
   function automatic int tmr_w(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/digit_reg.sv
// One code digit: DW-bit register with synchronous clear (priority) and load.
// Latency: q follows d one clock after ld; clr zeroes q one clock later.
// Backpressure: none; ld is accepted every cycle.
// Ports: clk, clr_n (async active-low reset to RST_VAL), clr, ld, d -> q.
module digit_reg
   import lock_pkg::*;
#(
   parameter int            DW      = DEF_DW,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          clr,
   input  logic          ld,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   logic [DW-1:0] r_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_q <= RST_VAL;
      end else if (clr) begin
         r_q <= '0;
      end else if (ld) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock sequencer: collects NDIG digits, checks them against the stored
// code, drives unlock / alarm / err / prog_ok, handles lockout and reprogramming.
// Latency: unlocked or FAIL one clock after the last digit; all outputs registered.
// Backpressure: none; keys arriving in states that do not collect digits are dropped.
// Ports: clk, clr_n (async active-low), key_vld/key, enter, prog in;
//        unlocked, alarm, err, prog_ok, dig_cnt, tries out.
module lock_ctrl
   import lock_pkg::*;
#(
   parameter int                   NDIG        = DEF_NDIG,
   parameter int                   DW          = DEF_DW,
   parameter int                   MAX_TRIES   = 3,
   parameter int                   UNLOCK_CYC  = 8,
   parameter int                   LOCKOUT_CYC = 16,
   parameter logic [NDIG*DW-1:0]   RESET_CODE  = 16'h1234
) (
   input  logic                           clk,
   input  logic                           clr_n,
   input  logic                           key_vld,
   input  logic [DW-1:0]                  key,
   input  logic                           enter,
   input  logic                           prog,
   output logic                           unlocked,
   output logic                           alarm,
   output logic                           err,
   output logic                           prog_ok,
   output logic [$clog2(NDIG+1)-1:0]      dig_cnt,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries
);

   localparam int CW  = cnt_w(NDIG);
   localparam int TW  = cnt_w(MAX_TRIES);
   localparam int TMW = tmr_w(UNLOCK_CYC, LOCKOUT_CYC);
   localparam int KW  = NDIG * DW;

   localparam logic [CW-1:0]  DIG_LAST   = CW'(NDIG - 1);
   localparam logic [TW-1:0]  TRIES_LAST = TW'(MAX_TRIES - 1);
   localparam logic [TMW-1:0] U_LOAD     = TMW'(UNLOCK_CYC - 1);
   localparam logic [TMW-1:0] L_LOAD     = TMW'(LOCKOUT_CYC - 1);

   lock_state_t    r_state;
   logic [CW-1:0]  r_dig_cnt;
   logic [TW-1:0]  r_tries;
   logic [TMW-1:0] r_timer;     // shared by OPEN and LOCKOUT
   logic           r_unlocked;
   logic           r_alarm;
   logic           r_err;
   logic           r_prog_ok;

   logic            w_take_key;
   logic [NDIG-1:0] w_ld_ent;
   logic            w_clr_ent;
   logic            w_ld_code;
   logic [KW-1:0]   w_entry;
   logic [KW-1:0]   w_code;
   logic            w_match;
   logic            w_tmr_zero;

   assign w_match    = (w_entry == w_code);
   assign w_tmr_zero = (r_timer == '0);
   assign w_ld_code  = (r_state == ST_COMMIT);

   // Digits fill from the MS index down, so the slot to load is NDIG-1-dig_cnt.
   always_comb begin
      w_take_key = key_vld && ((r_state == ST_IDLE) || (r_state == ST_ENTRY) ||
                               (r_state == ST_PROG));
      w_ld_ent = '0;
      for (int i = 0; i < NDIG; i++) begin
         w_ld_ent[i] = w_take_key && (r_dig_cnt == CW'(NDIG - 1 - i));
      end
   end

   // Entry is wiped on every path that abandons or consumes it, and on entering
   // PROG so the new code never inherits digits of the opening code.
   always_comb begin
      w_clr_ent = 1'b0;
      case (r_state)
         ST_FAIL:    w_clr_ent = 1'b1;
         ST_COMMIT:  w_clr_ent = 1'b1;
         ST_OPEN:    w_clr_ent = prog || w_tmr_zero;
         ST_PROG:    w_clr_ent = enter && !key_vld;
         ST_LOCKOUT: w_clr_ent = w_tmr_zero;
         default:    w_clr_ent = 1'b0;
      endcase
   end

   for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      digit_reg #(
         .DW      (DW),
         .RST_VAL ('0)
      ) u_ent (
         .clk   (clk),
         .clr_n (clr_n),
         .clr   (w_clr_ent),
         .ld    (w_ld_ent[gi]),
         .d     (key),
         .q     (w_entry[gi*DW +: DW])
      );

      digit_reg #(
         .DW      (DW),
         .RST_VAL (RESET_CODE[gi*DW +: DW])
      ) u_code (
         .clk   (clk),
         .clr_n (clr_n),
         .clr   (1'b0),
         .ld    (w_ld_code),
         .d     (w_entry[gi*DW +: DW]),
         .q     (w_code[gi*DW +: DW])
      );
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state    <= ST_IDLE;
         r_dig_cnt  <= '0;
         r_tries    <= '0;
         r_timer    <= '0;
         r_unlocked <= 1'b0;
         r_alarm    <= 1'b0;
         r_err      <= 1'b0;
         r_prog_ok  <= 1'b0;
      end else begin
         r_err     <= 1'b0;
         r_prog_ok <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (key_vld) begin
                  r_dig_cnt <= CW'(1);
                  r_state   <= (NDIG == 1) ? ST_CHECK : ST_ENTRY;
               end
            end

            ST_ENTRY: begin
               if (key_vld) begin
                  r_dig_cnt <= r_dig_cnt + CW'(1);
                  if (r_dig_cnt == DIG_LAST) r_state <= ST_CHECK;
               end else if (enter) begin
                  // Reaching NDIG digits always leaves ENTRY, so any enter here is short.
                  r_err   <= 1'b1;
                  r_state <= ST_FAIL;
               end
            end

            ST_CHECK: begin
               r_dig_cnt <= '0;
               if (w_match) begin
                  r_tries    <= '0;
                  r_timer    <= U_LOAD;
                  r_unlocked <= 1'b1;
                  r_state    <= ST_OPEN;
               end else if (r_tries == TRIES_LAST) begin
                  r_timer <= L_LOAD;
                  r_alarm <= 1'b1;
                  r_state <= ST_LOCKOUT;
               end else begin
                  r_err   <= 1'b1;
                  r_state <= ST_FAIL;
               end
            end

            ST_FAIL: begin
               r_dig_cnt <= '0;
               r_tries   <= r_tries + TW'(1);
               // Only a short entry can arrive here already at the last allowed try.
               if (r_tries == TRIES_LAST) begin
                  r_timer <= L_LOAD;
                  r_alarm <= 1'b1;
                  r_state <= ST_LOCKOUT;
               end else begin
                  r_state <= ST_IDLE;
               end
            end

            ST_OPEN: begin
               if (prog) begin
                  r_dig_cnt <= '0;
                  r_state   <= ST_PROG;
               end else if (w_tmr_zero) begin
                  r_unlocked <= 1'b0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_timer <= r_timer - TMW'(1);
               end
            end

            ST_PROG: begin
               if (key_vld) begin
                  r_dig_cnt <= r_dig_cnt + CW'(1);
                  if (r_dig_cnt == DIG_LAST) begin
                     r_prog_ok <= 1'b1;
                     r_state   <= ST_COMMIT;
                  end
               end else if (enter) begin
                  r_dig_cnt  <= '0;
                  r_unlocked <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end

            ST_COMMIT: begin
               r_dig_cnt  <= '0;
               r_unlocked <= 1'b0;
               r_state    <= ST_IDLE;
            end

            ST_LOCKOUT: begin
               if (w_tmr_zero) begin
                  r_alarm   <= 1'b0;
                  r_tries   <= '0;
                  r_dig_cnt <= '0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_timer <= r_timer - TMW'(1);
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign unlocked = r_unlocked;
   assign alarm    = r_alarm;
   assign err      = r_err;
   assign prog_ok  = r_prog_ok;
   assign dig_cnt  = r_dig_cnt;
   assign tries    = r_tries;

endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Keypad sequencing controller for the digital lock. Collects a fixed-length digit entry into per-digit load/clear registers, compares it against a stored code, and drives the unlock, alarm and error indications. Also handles lockout after repeated failures and reprogramming of the code while the lock is open. Sits between the keypad debouncer/encoder and the lock actuator/indicator logic.

## Interface
Parameters:
- `NDIG`, 4, number of digits per code.
- `DW`, 4, bits per digit.
- `MAX_TRIES`, 3, consecutive failed checks that trigger lockout (≥1).
- `UNLOCK_CYC`, 8, cycles `unlocked` stays high (≥2).
- `LOCKOUT_CYC`, 16, cycles `alarm` stays high (≥2).
- `RESET_CODE`, 16'h1234, code loaded at reset; width NDIG*DW.

Ports:
- `clk`  in  1  rising-edge clock; the block uses one clock only.
- `clr_n`  in  1  asynchronous, active-low reset.
- `key_vld`  in  1  one-cycle strobe; `key` is valid.
- `key`  in  DW  digit value; any value 0..2^DW-1 is accepted.
- `enter`  in  1  one-cycle strobe; terminates entry early.
- `prog`  in  1  one-cycle strobe; requests code reprogramming.
- `unlocked`  out  1  lock open.
- `alarm`  out  1  lockout active.
- `err`  out  1  one-cycle pulse on a failed attempt.
- `prog_ok`  out  1  one-cycle pulse when a new code is committed.
- `dig_cnt`  out  clog2(NDIG+1)  digits collected in the current entry.
- `tries`  out  clog2(MAX_TRIES+1)  consecutive failures.

## Operation
- Storage: NDIG entry registers and NDIG code registers. Each register has synchronous clear and load. Digit i is loaded from `key` when the controller strobes its load.
- The first key of an entry goes to the MS digit (index NDIG-1). Entering 1,2,3,4 therefore forms 16'h1234.
- States: IDLE, ENTRY, CHECK, FAIL, OPEN, PROG, COMMIT, LOCKOUT.
- IDLE: on `key_vld`, load digit NDIG-1, set `dig_cnt`=1 and go to ENTRY. `enter` and `prog` are ignored.
- ENTRY:
  - On `key_vld`, load the next digit and increment `dig_cnt`. When the load is digit index 0, go to CHECK.
  - `enter` with `dig_cnt`<NDIG goes to FAIL. A short entry is a failure and counts toward `tries`.
  - If `key_vld` and `enter` arrive in the same cycle, `key_vld` wins and `enter` is dropped.
- CHECK (one cycle, all inputs ignored):
  - Entry equals code: go to OPEN and set `tries`=0.
  - No match and `tries`+1 == MAX_TRIES: go to LOCKOUT.
  - Otherwise: go to FAIL.
- FAIL (one cycle):
  - `err`=1, `tries` increments, entry registers clear, `dig_cnt`=0, then go to IDLE.
  - A short entry whose failure reaches MAX_TRIES goes to LOCKOUT instead of IDLE. `err` still pulses in this case.
- OPEN:
  - `unlocked`=1 for UNLOCK_CYC cycles, then go to IDLE and clear the entry registers. `key_vld` and `enter` are ignored.
  - `prog` goes to PROG and takes priority over timer expiry in the same cycle.
- PROG:
  - `unlocked` stays 1 and there is no timeout. Keys are collected exactly as in ENTRY.
  - After NDIG digits, go to COMMIT.
  - `enter` before NDIG digits aborts to IDLE. The code is unchanged and there is no `err`.
- COMMIT (one cycle): copy the entry registers to the code registers, pulse `prog_ok`=1, clear the entry, go to IDLE.
- LOCKOUT:
  - `alarm`=1 for LOCKOUT_CYC cycles. All inputs are ignored.
  - Then go to IDLE with `tries`=0 and the entry cleared.

## Timing
- All outputs are registered and decoded from the state register; there are no combinational input-to-output paths.
- Reset (`clr_n`=0, at any time, mid-entry included):
  - State IDLE; code registers = RESET_CODE; entry registers = 0.
  - All counters = 0.
  - `unlocked`=`alarm`=`err`=`prog_ok`=0.
- Last digit sampled at edge t: CHECK during cycle t..t+1. At edge t+1 either `unlocked`=1 (match) or FAIL is entered, with `err` high for the cycle after t+1.
- `unlocked` is high for exactly UNLOCK_CYC cycles when `prog` is not used. `alarm` is high for exactly LOCKOUT_CYC cycles.
- `dig_cnt` updates on the same edge as the digit load.
- `tries` updates on the edge leaving FAIL, or is zeroed leaving CHECK on a match.

## Structure
- Package `lock_pkg`: state enum `lock_state_t`; `CODE_W` = NDIG*DW; width helpers for the counters.
- Sub-module `digit_reg` (DW-bit register with `ld` and synchronous `clr`, async `clr_n`, reset-value parameter). Instantiated 2×NDIG times.
- One shared down-counter serves both UNLOCK_CYC and LOCKOUT_CYC.

## Test plan
- Reset, then keys 1,2,3,4: `unlocked`=1 at the edge after the 4th key, for 8 cycles, then 0; `tries`=0.
- Keys 1,2,3,5: `err` pulse, `tries`=1, `dig_cnt` returns to 0. Next, keys 1,2,3,4 open the lock and `tries`=0.
- Three wrong codes (9,9,9,9): `err`×2, then the third entry goes to LOCKOUT. `alarm`=1 for 16 cycles, keys during it are ignored, then `tries`=0.
- Key 1 then `enter`: `err` pulse, `tries`=1. Same-cycle `key_vld`=7 with `enter` in ENTRY: digit stored, no `err`.
- Open with 1234, `prog`, keys 5,6,7,8: `prog_ok` pulse; 1234 now fails; 5678 opens. `prog` then `enter` after 2 keys: code unchanged.
- `clr_n` low after 2 keys, or during OPEN or LOCKOUT: all outputs 0 and code back to 16'h1234 even after reprogramming.
